// File: rtl/hand_scorer_if.sv
// Vaza/command inputs and hand/score outputs of the truco hand scorer.
// master drives vaza results and commands; slave is the scorer itself.
interface hand_scorer_if #(
  parameter int unsigned PW = 4,
  parameter int unsigned SW = 5
);
  logic          v1;
  logic          v2;
  logic          e;
  logic          newhand;
  logic          newgame;
  logic [PW-1:0] pont;

  logic [PW-1:0] s;
  logic          v;
  logic          tie;
  logic          done;
  logic [SW-1:0] score1;
  logic [SW-1:0] score2;
  logic          gameover;
  logic          err;

  modport master (
    output v1, v2, e, newhand, newgame, pont,
    input  s, v, tie, done, score1, score2, gameover, err
  );

  modport slave (
    input  v1, v2, e, newhand, newgame, pont,
    output s, v, tie, done, score1, score2, gameover, err
  );
endinterface

// File: rtl/hand_scorer.sv
// Truco hand resolver and match scorekeeper: resolves each hand from up to three
// vaza results, awards the hand value and tracks both scores up to TARGET.
module hand_scorer #(
  parameter int unsigned PW     = 4,
  parameter int unsigned SW     = 5,
  parameter int unsigned TARGET = 12
) (
  input logic          clk,
  input logic          clr,
  hand_scorer_if.slave bus
);

  // Sum width wide enough for score + pont without wrap-around.
  localparam int unsigned AW = ((SW > PW) ? SW : PW) + 1;

  typedef enum logic [1:0] {W1, W2, W3, OVER} state_t;
  typedef enum logic [1:0] {R_EMP, R_T1, R_T2} res_t;

  state_t        state;
  res_t          r1;
  logic [PW-1:0] s_q;
  logic          v_q;
  logic          tie_q;
  logic          done_q;
  logic [SW-1:0] score1_q;
  logic [SW-1:0] score2_q;
  logic          gameover_q;
  logic          err_q;

  logic [1:0]    ev_cnt_c;
  logic          single_c;
  logic          multi_c;
  res_t          res_c;
  res_t          win_c;
  logic          tie_c;
  state_t        next_wait_c;
  logic [AW-1:0] base_c;
  logic [AW-1:0] sum_c;
  logic [AW-1:0] sat_c;
  logic          hit_c;
  logic [SW-1:0] new_score_c;

  assign ev_cnt_c = 2'(bus.v1) + 2'(bus.v2) + 2'(bus.e);
  assign single_c = (ev_cnt_c == 2'd1);
  assign multi_c  = (ev_cnt_c > 2'd1);

  always_comb begin
    res_c = R_EMP;
    if (bus.v1)      res_c = R_T1;
    else if (bus.v2) res_c = R_T2;
  end

  // Hand decision for the current vaza given the vaza-1 result.
  always_comb begin
    win_c       = R_EMP;
    tie_c       = 1'b0;
    next_wait_c = state;
    case (state)
      W2: begin
        if (r1 == R_EMP) begin
          if (res_c != R_EMP) win_c = res_c;
          else                next_wait_c = W3;
        end else if (res_c == r1 || res_c == R_EMP) begin
          win_c = r1;
        end else begin
          next_wait_c = W3;
        end
      end
      W3: begin
        if (res_c != R_EMP)   win_c = res_c;
        else if (r1 != R_EMP) win_c = r1;
        else                  tie_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Winner's saturated score.
  always_comb begin
    base_c      = (win_c == R_T2) ? AW'(score2_q) : AW'(score1_q);
    sum_c       = base_c + AW'(bus.pont);
    sat_c       = (sum_c >= AW'(TARGET)) ? AW'(TARGET) : sum_c;
    hit_c       = (sat_c == AW'(TARGET));
    new_score_c = SW'(sat_c);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= W1;
      r1         <= R_EMP;
      s_q        <= '0;
      v_q        <= 1'b0;
      tie_q      <= 1'b0;
      done_q     <= 1'b0;
      score1_q   <= '0;
      score2_q   <= '0;
      gameover_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s_q    <= '0;
      v_q    <= 1'b0;
      tie_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.newgame) begin
        state      <= W1;
        r1         <= R_EMP;
        score1_q   <= '0;
        score2_q   <= '0;
        gameover_q <= 1'b0;
      end else if (state == OVER) begin
        state <= OVER;
      end else if (bus.newhand) begin
        state <= W1;
        r1    <= R_EMP;
      end else if (multi_c) begin
        err_q <= 1'b1;
      end else if (single_c) begin
        if (state == W1) begin
          r1    <= res_c;
          state <= W2;
        end else if (win_c != R_EMP) begin
          done_q <= 1'b1;
          s_q    <= bus.pont;
          v_q    <= (win_c == R_T2);
          r1     <= R_EMP;
          if (win_c == R_T2) score2_q <= new_score_c;
          else               score1_q <= new_score_c;
          if (hit_c) begin
            state      <= OVER;
            gameover_q <= 1'b1;
          end else begin
            state <= W1;
          end
        end else if (tie_c) begin
          tie_q <= 1'b1;
          r1    <= R_EMP;
          state <= W1;
        end else begin
          state <= next_wait_c;
        end
      end
    end
  end

  assign bus.s        = s_q;
  assign bus.v        = v_q;
  assign bus.tie      = tie_q;
  assign bus.done     = done_q;
  assign bus.score1   = score1_q;
  assign bus.score2   = score2_q;
  assign bus.gameover = gameover_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_hand_scorer.sv
// Self-checking bench for hand_scorer: directed scenarios plus randomized traffic
// compared every cycle against a vaza-counting reference model.
module tb_hand_scorer;

  localparam int unsigned PW = 4;
  localparam int unsigned SW = 5;
  localparam int unsigned TARGET = 12;

  logic clk;
  logic clr;
  hand_scorer_if #(.PW(PW), .SW(SW)) bus ();

  hand_scorer #(.PW(PW), .SW(SW), .TARGET(TARGET)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: scores, match-over flag, vaza results of the hand so far.
  int m_sc1, m_sc2, m_s, m_v, m_tie, m_done, m_err, m_over;
  int hist[3];
  int hlen;

  function automatic void model_reset();
    m_sc1 = 0; m_sc2 = 0; m_s = 0; m_v = 0; m_tie = 0; m_done = 0; m_err = 0;
    m_over = 0; hlen = 0;
  endfunction

  // 0 pending, 1 team1, 2 team2, 3 tie. Results: 0 tie, 1 team1, 2 team2.
  function automatic int decide();
    int w1 = 0, w2 = 0;
    for (int i = 0; i < hlen; i++) begin
      if (hist[i] == 1) w1++;
      if (hist[i] == 2) w2++;
    end
    if (hlen < 2) return 0;
    if (w1 > w2) return 1;
    if (w2 > w1) return 2;
    if (hlen < 3) return 0;
    if (hist[0] != 0) return hist[0];
    return 3;
  endfunction

  function automatic void model_step(bit a, bit b, bit c, bit nh, bit ng, int p);
    int n = int'(a) + int'(b) + int'(c);
    int w;
    m_s = 0; m_v = 0; m_tie = 0; m_done = 0; m_err = 0;
    if (ng) begin
      m_sc1 = 0; m_sc2 = 0; m_over = 0; hlen = 0;
    end else if (m_over != 0) begin
    end else if (nh) begin
      hlen = 0;
    end else if (n > 1) begin
      m_err = 1;
    end else if (n == 1) begin
      hist[hlen] = a ? 1 : (b ? 2 : 0);
      hlen++;
      w = decide();
      if (w == 1 || w == 2) begin
        m_done = 1; m_s = p; m_v = (w == 2) ? 1 : 0;
        if (w == 1) begin
          m_sc1 = (m_sc1 + p > TARGET) ? TARGET : m_sc1 + p;
          if (m_sc1 == TARGET) m_over = 1;
        end else begin
          m_sc2 = (m_sc2 + p > TARGET) ? TARGET : m_sc2 + p;
          if (m_sc2 == TARGET) m_over = 1;
        end
        hlen = 0;
      end else if (w == 3) begin
        m_tie = 1;
        hlen = 0;
      end
    end
  endfunction

  function automatic logic [18:0] exp_vec();
    return {4'(m_s), 1'(m_v), 1'(m_tie), 1'(m_done), 5'(m_sc1), 5'(m_sc2), 1'(m_over), 1'(m_err)};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {bus.s, bus.v, bus.tie, bus.done, bus.score1, bus.score2, bus.gameover, bus.err};
  endfunction

  // Apply one cycle of inputs, clock it and advance the model; sample #1 after the edge.
  task automatic drive(bit a, bit b, bit c, bit nh, bit ng, int p);
    bus.v1 = a; bus.v2 = b; bus.e = c; bus.newhand = nh; bus.newgame = ng;
    bus.pont = PW'(p);
    @(posedge clk);
    model_step(a, b, c, nh, ng, p);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.v1 = 0; bus.v2 = 0; bus.e = 0; bus.newhand = 0; bus.newgame = 0; bus.pont = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== 19'd0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0", obs_vec());
    end
    clr = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic_win();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 3);
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_first_vaza done=%b want=0", bus.done); end
    drive(1, 0, 0, 0, 0, 3);
    checks++;
    if ({bus.done, bus.s, bus.v, bus.score1, bus.score2} !== {1'b1, 4'd3, 1'b0, 5'd3, 5'd0}) begin
      failures++;
      $display("FAIL basic_win done=%b s=%0d v=%b s1=%0d s2=%0d want 1 3 0 3 0",
               bus.done, bus.s, bus.v, bus.score1, bus.score2);
    end
    drive(0, 0, 0, 0, 0, 3);
    checks++;
    if (bus.done !== 1'b0 || bus.s !== 4'd0) begin
      failures++; $display("FAIL basic_done_pulse done=%b s=%0d want 0 0", bus.done, bus.s);
    end
  endtask

  task automatic test_tie_rules();
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    checks++;
    if ({bus.done, bus.v, bus.score2} !== {1'b1, 1'b1, 5'd1}) begin
      failures++; $display("FAIL emp_then_t2 done=%b v=%b s2=%0d want 1 1 1", bus.done, bus.v, bus.score2);
    end
    drive(0, 0, 1, 0, 0, 5);
    drive(0, 0, 1, 0, 0, 5);
    drive(0, 0, 1, 0, 0, 5);
    checks++;
    if ({bus.tie, bus.done, bus.score1, bus.score2} !== {1'b1, 1'b0, 5'd0, 5'd1}) begin
      failures++;
      $display("FAIL triple_tie tie=%b done=%b s1=%0d s2=%0d want 1 0 0 1",
               bus.tie, bus.done, bus.score1, bus.score2);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.tie !== 1'b0) begin failures++; $display("FAIL tie_pulse tie=%b want 0", bus.tie); end
  endtask

  task automatic test_first_vaza();
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 6);
    drive(0, 0, 1, 0, 0, 6);
    checks++;
    if ({bus.done, bus.v, bus.s, bus.score2, bus.score1} !== {1'b1, 1'b1, 4'd6, 5'd6, 5'd0}) begin
      failures++;
      $display("FAIL first_vaza_rule done=%b v=%b s=%0d s2=%0d s1=%0d want 1 1 6 6 0",
               bus.done, bus.v, bus.s, bus.score2, bus.score1);
    end
  endtask

  task automatic test_gameover();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 10);
    drive(1, 0, 0, 0, 0, 10);
    drive(1, 0, 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 6);
    checks++;
    if ({bus.done, bus.score1, bus.gameover} !== {1'b1, 5'd12, 1'b1}) begin
      failures++; $display("FAIL saturate_gameover done=%b s1=%0d go=%b want 1 12 1",
                           bus.done, bus.score1, bus.gameover);
    end
    drive(0, 1, 0, 0, 0, 4);
    drive(0, 1, 0, 0, 0, 4);
    checks++;
    if ({bus.done, bus.score2, bus.gameover, bus.err} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL over_ignores done=%b s2=%0d go=%b err=%b want 0 0 1 0",
                           bus.done, bus.score2, bus.gameover, bus.err);
    end
    drive(1, 0, 1, 1, 0, 4);
    checks++;
    if (bus.err !== 1'b0) begin failures++; $display("FAIL over_no_err err=%b want 0", bus.err); end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if ({bus.score1, bus.score2, bus.gameover} !== {5'd0, 5'd0, 1'b0}) begin
      failures++; $display("FAIL newgame_clear s1=%0d s2=%0d go=%b want 0 0 0",
                           bus.score1, bus.score2, bus.gameover);
    end
  endtask

  task automatic test_err();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 2);
    checks++;
    if (bus.err !== 1'b1) begin failures++; $display("FAIL err_pulse err=%b want 1", bus.err); end
    drive(0, 1, 0, 0, 0, 2);
    checks++;
    if (bus.err !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL err_one_cycle err=%b done=%b want 0 0", bus.err, bus.done);
    end
    drive(0, 1, 0, 0, 0, 2);
    checks++;
    if ({bus.done, bus.score2} !== {1'b1, 5'd2}) begin
      failures++; $display("FAIL err_stays_w1 done=%b s2=%0d want 1 2", bus.done, bus.score2);
    end
  endtask

  task automatic test_newhand();
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 3);
    drive(0, 1, 0, 1, 0, 3);
    checks++;
    if ({bus.done, bus.score2} !== {1'b0, 5'd0}) begin
      failures++; $display("FAIL newhand_abort done=%b s2=%0d want 0 0", bus.done, bus.score2);
    end
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    checks++;
    if ({bus.done, bus.score1} !== {1'b1, 5'd1}) begin
      failures++; $display("FAIL newhand_restart done=%b s1=%0d want 1 1", bus.done, bus.score1);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 2);
    drive(0, 0, 1, 0, 0, 2);
    drive(0, 1, 0, 0, 0, 4);
    checks++;
    if ({bus.done, bus.v, bus.score1} !== {1'b0, 1'b0, 5'd2}) begin
      failures++; $display("FAIL b2b_first done=%b v=%b s1=%0d want 0 0 2", bus.done, bus.v, bus.score1);
    end
    drive(0, 1, 0, 0, 0, 4);
    checks++;
    if ({bus.done, bus.v, bus.score2} !== {1'b1, 1'b1, 5'd4}) begin
      failures++; $display("FAIL b2b_second done=%b v=%b s2=%0d want 1 1 4", bus.done, bus.v, bus.score2);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL b2b_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_clr_async();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 5);
    drive(1, 0, 0, 0, 0, 5);
    drive(1, 0, 0, 0, 0, 5);
    drive(0, 1, 0, 0, 0, 5);
    bus.v1 = 0; bus.v2 = 0;
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== 19'd0) begin
      failures++; $display("FAIL clr_async got=%h want=0", obs_vec());
    end
    #1;
    clr = 1'b0;
    drive(1, 0, 0, 0, 0, 2);
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL clr_vaza1 done=%b want 0", bus.done); end
    drive(1, 0, 0, 0, 0, 2);
    checks++;
    if ({bus.done, bus.score1} !== {1'b1, 5'd2}) begin
      failures++; $display("FAIL clr_restart done=%b s1=%0d want 1 2", bus.done, bus.score1);
    end
  endtask

  task automatic test_random();
    int r, k;
    bit a, b, c, nh, ng;
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      a = 0; b = 0; c = 0;
      if (r < 45) begin
        k = int'($urandom_range(0, 2));
        a = (k == 0); b = (k == 1); c = (k == 2);
      end else if (r < 52) begin
        a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); c = 1'b1;
        if (!a && !b) a = 1'b1;
      end
      nh = ($urandom_range(0, 24) == 0);
      ng = ($urandom_range(0, 39) == 0);
      drive(a, b, c, nh, ng, int'($urandom_range(0, 15)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_win();
    test_tie_rules();
    test_first_vaza();
    test_gameover();
    test_err();
    test_newhand();
    test_back_to_back();
    test_clr_async();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hand_scorer.md
# hand_scorer

Parametrised truco hand resolver and match scorekeeper. It consumes per-trick (vaza) results, decides the hand winner using the full three-vaza tie-break rules, and awards the hand value. It accumulates both teams' scores with saturation at a configurable target and flags game over. It sits between the vaza comparator logic and the score display, and replaces single-hand point distribution with a complete match-level block.

## Interface
- PW, 4, width of hand value input Pont and award output S
- SW, 5, width of score accumulators; must hold TARGET
- TARGET, 12, winning score; accumulators saturate here
- Clk  in  1  system clock, rising-edge active
- Clr  in  1  asynchronous, active-high reset of all state and outputs
- V1  in  1  team 1 won the current vaza (one-cycle pulse)
- V2  in  1  team 2 won the current vaza (one-cycle pulse)
- E  in  1  current vaza tied (empate) (one-cycle pulse)
- NewHand  in  1  synchronous abort of the hand in progress; no points awarded
- NewGame  in  1  synchronous clear of scores, GameOver and hand state
- Pont  in  PW  value of the hand in play; sampled on the deciding vaza
- S  out  PW  points awarded; valid while Done=1, else 0
- V  out  1  hand winner while Done=1 (0 = team 1, 1 = team 2), else 0
- Tie  out  1  hand fully tied (three E vazas); one-cycle pulse, no award
- Done  out  1  one-cycle pulse: hand resolved
- Score1  out  SW  team 1 accumulated score
- Score2  out  SW  team 2 accumulated score
- GameOver  out  1  a score has reached TARGET; held until Clr or NewGame
- Err  out  1  one-cycle pulse: more than one of V1/V2/E high in the same cycle

## Operation
- Vaza event: exactly one of V1/V2/E high at a rising Clk edge. If more than one is high, the event is ignored, state is unchanged, and Err pulses.
- FSM states: W1 (awaiting vaza 1), W2 (awaiting vaza 2), W3 (awaiting vaza 3), OVER. Register R1 holds the vaza-1 result: T1, T2 or EMP.
- W1 → W2 on any event. R1 ← result.
- W2:
  - R1=EMP, second result T1 or T2 → resolve for that team.
  - R1=EMP, second result EMP → W3.
  - R1=Tx, second result Tx or EMP → resolve for Tx.
  - R1=Tx, second result Ty (y≠x) → W3.
- W3:
  - Result T1 or T2 → resolve for that team.
  - Result EMP with R1=Tx → resolve for Tx.
  - Result EMP with R1=EMP → Tie pulse, no award.
- Resolve: S ← Pont sampled in the deciding cycle. V ← winner. Winner's score ← min(score + Pont, TARGET). FSM → W1, or → OVER if the new score equals TARGET.
- OVER: all vaza events and NewHand are ignored. No Err is raised. Only NewGame or Clr leaves OVER, returning to W1.
- NewHand: FSM → W1, R1 cleared, scores untouched. NewHand has priority over a simultaneous vaza event; that event is discarded.
- NewGame: scores → 0, GameOver → 0, FSM → W1. NewGame has priority over NewHand and over vaza events.
- Pont=0 on a deciding vaza: Done pulses with S=0 and scores are unchanged.
- Arithmetic: the sum is computed at SW+1 bits before the saturation compare, so no wrap-around occurs.

## Timing
- All outputs are registered.
- Clr values: S=0, V=0, Tie=0, Done=0, Err=0, Score1=0, Score2=0, GameOver=0. FSM=W1, R1=EMP.
- Clr mid-hand takes effect immediately and asynchronously. Release is synchronous to the next Clk edge.
- Latency: the deciding vaza is sampled at edge N. Done, S, V and the updated Score1/Score2 are visible after edge N; Done is high for exactly one cycle. GameOver rises in the same cycle as that Done.
- Tie and Err each appear one cycle after the offending edge, for one cycle.
- Back-to-back vaza events on consecutive cycles are legal. A vaza event in the Done cycle counts as vaza 1 of the next hand.
- Pont and the score outputs have no handshake. Pont only needs to be stable at the deciding edge.

## Test plan
- Vaza sequence V1, V1, Pont=3 → Done after the 2nd event; S=3, V=0, Score1=3, Score2=0.
- Vaza sequence E, V2, Pont=1 → resolved at the 2nd event; V=1, Score2=1. Sequence E, E, E → Tie pulse, no Done, scores unchanged.
- Vaza sequence V2, V1, E, Pont=6 → team 2 wins on the first-vaza rule; Score2 += 6.
- Score1=10, team 1 wins a hand with Pont=6 → Score1=12, GameOver=1. A following V2, V2 → no Done, no change. NewGame → all scores 0, GameOver=0.
- V1 and E high together → Err pulse, FSM stays in W1. NewHand together with V2 in W2 → abort, back to W1, no score.
- Clr asserted while in W3 → all outputs 0 immediately, without a clock edge. The next V1 is treated as vaza 1.
